// File: rtl/life_grid_16x16.sv
// ============================================================================
//  Module   : life_grid_16x16
//  Brief    : 16x16 Game of Life cell array, 4x4 block host access, tileable
//             through edge and corner neighbour ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_grid_16x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] vali,
    input  logic [3:0]  vali_selector,
    input  logic [3:0]  valo_selector,
    input  logic        write_enb,
    input  logic        step,
    output logic [15:0] valo,
    output logic [15:0] valo_prev,
    input  logic [15:0] ni,
    input  logic [15:0] si,
    input  logic [15:0] wi,
    input  logic [15:0] ei,
    input  logic        nwi,
    input  logic        nei,
    input  logic        sei,
    input  logic        swi,
    output logic [15:0] no,
    output logic [15:0] so,
    output logic [15:0] wo,
    output logic [15:0] eo,
    output logic        nwo,
    output logic        neo,
    output logic        seo,
    output logic        swo
);

    localparam int c_N = 16;

    // Cells indexed [row][col]
    logic [c_N-1:0][c_N-1:0] r_cur;
    logic [c_N-1:0][c_N-1:0] r_prev;
    logic [c_N-1:0][c_N-1:0] w_next;

    // Array surrounded by a one-cell ring of virtual neighbours
    logic [c_N+1:0][c_N+1:0] w_ext;

    always_comb begin
        w_ext            = '0;
        w_ext[0][0]      = nwi;
        w_ext[0][c_N+1]  = nei;
        w_ext[c_N+1][0]  = swi;
        w_ext[c_N+1][c_N+1] = sei;
        for (int i = 0; i < c_N; i++) begin
            w_ext[0][i+1]     = ni[i];
            w_ext[c_N+1][i+1] = si[i];
            w_ext[i+1][0]     = wi[i];
            w_ext[i+1][c_N+1] = ei[i];
            for (int j = 0; j < c_N; j++) begin
                w_ext[i+1][j+1] = r_cur[i][j];
            end
        end
    end

    generate
        for (genvar gr = 0; gr < c_N; gr++) begin : g_row
            for (genvar gc = 0; gc < c_N; gc++) begin : g_col
                logic [3:0] w_cnt;
                assign w_cnt = {3'b000, w_ext[gr][gc]}   + {3'b000, w_ext[gr][gc+1]}
                             + {3'b000, w_ext[gr][gc+2]} + {3'b000, w_ext[gr+1][gc]}
                             + {3'b000, w_ext[gr+1][gc+2]} + {3'b000, w_ext[gr+2][gc]}
                             + {3'b000, w_ext[gr+2][gc+1]} + {3'b000, w_ext[gr+2][gc+2]};
                assign w_next[gr][gc] = (w_cnt == 4'd3) ||
                                        (r_cur[gr][gc] && (w_cnt == 4'd2));
            end
        end
    endgenerate

    // Block word bit b maps to row {sel[1:0], b[1:0]}, column {sel[3:2], b[3:2]}
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= '0;
            r_prev <= '0;
        end else if (write_enb) begin
            for (int b = 0; b < 16; b++) begin
                r_cur[{vali_selector[1:0], b[1:0]}][{vali_selector[3:2], b[3:2]}] <= vali[b];
            end
        end else if (step) begin
            r_prev <= r_cur;
            r_cur  <= w_next;
        end
    end

    always_comb begin
        valo      = '0;
        valo_prev = '0;
        for (int b = 0; b < 16; b++) begin
            valo[b]      = r_cur[{valo_selector[1:0], b[1:0]}][{valo_selector[3:2], b[3:2]}];
            valo_prev[b] = r_prev[{valo_selector[1:0], b[1:0]}][{valo_selector[3:2], b[3:2]}];
        end
    end

    assign no  = r_cur[0];
    assign so  = r_cur[c_N-1];
    assign nwo = r_cur[0][0];
    assign neo = r_cur[0][c_N-1];
    assign seo = r_cur[c_N-1][c_N-1];
    assign swo = r_cur[c_N-1][0];

    generate
        for (genvar gj = 0; gj < c_N; gj++) begin : g_side
            assign wo[gj] = r_cur[gj][0];
            assign eo[gj] = r_cur[gj][c_N-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_life_grid_16x16.sv
// ============================================================================
//  Module   : tb_life_grid_16x16
//  Brief    : Directed table-driven bench for life_grid_16x16.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_life_grid_16x16;

    logic        clk = 1'b0;
    logic        reset, write_enb, step;
    logic [15:0] vali;
    logic [3:0]  vali_selector, valo_selector;
    logic [15:0] valo, valo_prev;
    logic [15:0] ni, si, wi, ei;
    logic        nwi, nei, sei, swi;
    logic [15:0] no, so, wo, eo;
    logic        nwo, neo, seo, swo;

    life_grid_16x16 dut (
        .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
        .valo_selector(valo_selector), .write_enb(write_enb), .step(step),
        .valo(valo), .valo_prev(valo_prev),
        .ni(ni), .si(si), .wi(wi), .ei(ei),
        .nwi(nwi), .nei(nei), .sei(sei), .swi(swi),
        .no(no), .so(so), .wo(wo), .eo(eo),
        .nwo(nwo), .neo(neo), .seo(seo), .swo(swo)
    );

    always #5 clk = ~clk;

    localparam int c_OP_RST  = 0;
    localparam int c_OP_WR   = 1;
    localparam int c_OP_STEP = 2;
    localparam int c_OP_NI   = 3;   // data -> ni
    localparam int c_OP_WI   = 4;   // data -> wi
    localparam int c_OP_SI   = 5;   // data -> si
    localparam int c_OP_EI   = 6;   // data -> ei
    localparam int c_OP_CIN  = 7;   // data[3:0] -> {nwi,nei,sei,swi}
    localparam int c_OP_VALO = 8;
    localparam int c_OP_PREV = 9;
    localparam int c_OP_NO   = 10;
    localparam int c_OP_SO   = 11;
    localparam int c_OP_WO   = 12;
    localparam int c_OP_EO   = 13;
    localparam int c_OP_COUT = 14;  // expected {nwo,neo,seo,swo}

    typedef struct {
        int          op;
        logic [3:0]  sel;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input int op, input logic [3:0] sel, input logic [15:0] data);
        vec_t v;
        v.op = op; v.sel = sel; v.data = data;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] sel, input logic [15:0] data);
        write_enb = 1'b1; vali_selector = sel; vali = data;
        tick();
        write_enb = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic read(input logic [3:0] sel);
        valo_selector = sel;
        #1;
    endtask

    initial begin
        reset = 0; write_enb = 0; step = 0; vali = '0;
        vali_selector = '0; valo_selector = '0;
        ni = '0; si = '0; wi = '0; ei = '0;
        nwi = 0; nei = 0; sei = 0; swi = 0;

        // Single cell at (0,0)
        add(c_OP_RST, 0, 0);
        add(c_OP_VALO, 4'h0, 16'h0000);
        add(c_OP_PREV, 4'h0, 16'h0000);
        add(c_OP_WR,   4'h0, 16'h0001);
        add(c_OP_VALO, 4'h0, 16'h0001);
        add(c_OP_COUT, 4'h0, 16'h0008);
        add(c_OP_VALO, 4'h1, 16'h0000);
        add(c_OP_VALO, 4'h4, 16'h0000);
        add(c_OP_VALO, 4'hF, 16'h0000);
        // Full top row
        add(c_OP_RST, 0, 0);
        add(c_OP_WR,  4'h0, 16'h1111);
        add(c_OP_WR,  4'h4, 16'h1111);
        add(c_OP_WR,  4'h8, 16'h1111);
        add(c_OP_WR,  4'hC, 16'h1111);
        add(c_OP_NO,  0, 16'hFFFF);
        add(c_OP_WO,  0, 16'h0001);
        add(c_OP_SO,  0, 16'h0000);
        add(c_OP_EO,  0, 16'h0001);
        add(c_OP_COUT, 0, 16'h000C);
        // Block still life in the corner
        add(c_OP_RST, 0, 0);
        add(c_OP_WR,   4'h0, 16'h0033);
        add(c_OP_STEP, 0, 0);
        add(c_OP_STEP, 0, 0);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h0, 16'h0033);
        add(c_OP_PREV, 4'h0, 16'h0033);
        // Vertical blinker across blocks 5 and 6
        add(c_OP_RST, 0, 0);
        add(c_OP_WR,   4'h5, 16'h0800);
        add(c_OP_WR,   4'h6, 16'h0300);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h6, 16'h1110);
        add(c_OP_VALO, 4'h5, 16'h0000);
        add(c_OP_PREV, 4'h6, 16'h0300);
        add(c_OP_PREV, 4'h5, 16'h0800);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h6, 16'h0300);
        add(c_OP_VALO, 4'h5, 16'h0800);
        // Birth from the north virtual row
        add(c_OP_RST,  0, 0);
        add(c_OP_NI,   0, 16'h0007);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h0, 16'h0010);
        add(c_OP_NI,   0, 16'h0000);
        // Birth from the west virtual column: (1,0)
        add(c_OP_RST,  0, 0);
        add(c_OP_WI,   0, 16'h0007);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h0, 16'h0002);
        add(c_OP_WO,   0, 16'h0002);
        add(c_OP_WI,   0, 16'h0000);
        // Birth at (0,0) from nwi + ni[0] + ni[1]
        add(c_OP_RST,  0, 0);
        add(c_OP_CIN,  0, 16'h0008);
        add(c_OP_NI,   0, 16'h0003);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'h0, 16'h0001);
        add(c_OP_CIN,  0, 16'h0000);
        add(c_OP_NI,   0, 16'h0000);
        // Birth at (15,15) from sei + si[15] + ei[15]
        add(c_OP_RST,  0, 0);
        add(c_OP_CIN,  0, 16'h0002);
        add(c_OP_SI,   0, 16'h8000);
        add(c_OP_EI,   0, 16'h8000);
        add(c_OP_STEP, 0, 0);
        add(c_OP_VALO, 4'hF, 16'h8000);
        add(c_OP_COUT, 0, 16'h0002);
        add(c_OP_SO,   0, 16'h8000);
        add(c_OP_EO,   0, 16'h8000);
        add(c_OP_CIN,  0, 16'h0000);
        add(c_OP_SI,   0, 16'h0000);
        add(c_OP_EI,   0, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d_op%0d_sel%0h", i, tbl[i].op, tbl[i].sel);
            case (tbl[i].op)
                c_OP_RST:  do_reset();
                c_OP_WR:   do_write(tbl[i].sel, tbl[i].data);
                c_OP_STEP: do_step();
                c_OP_NI:   ni = tbl[i].data;
                c_OP_WI:   wi = tbl[i].data;
                c_OP_SI:   si = tbl[i].data;
                c_OP_EI:   ei = tbl[i].data;
                c_OP_CIN:  {nwi, nei, sei, swi} = tbl[i].data[3:0];
                c_OP_VALO: begin read(tbl[i].sel); check(nm, valo, tbl[i].data); end
                c_OP_PREV: begin read(tbl[i].sel); check(nm, valo_prev, tbl[i].data); end
                c_OP_NO:   begin #1; check(nm, no, tbl[i].data); end
                c_OP_SO:   begin #1; check(nm, so, tbl[i].data); end
                c_OP_WO:   begin #1; check(nm, wo, tbl[i].data); end
                c_OP_EO:   begin #1; check(nm, eo, tbl[i].data); end
                c_OP_COUT: begin #1; check(nm, {12'h000, nwo, neo, seo, swo}, tbl[i].data); end
                default:   ;
            endcase
        end

        // Write wins over step, and prev is left alone
        do_reset();
        do_write(4'h0, 16'h0001);
        do_step();                                  // lone cell dies, prev holds it
        write_enb = 1'b1; step = 1'b1; vali_selector = 4'h0; vali = 16'h0033;
        tick();
        write_enb = 1'b0; step = 1'b0;
        read(4'h0);
        check("wr_over_step_cur", valo, 16'h0033);
        check("wr_over_step_prev", valo_prev, 16'h0001);

        // Reset wins over step
        reset = 1'b1; step = 1'b1;
        tick();
        reset = 1'b0; step = 1'b0;
        read(4'h0);
        check("rst_over_step_cur", valo, 16'h0000);
        check("rst_over_step_prev", valo_prev, 16'h0000);

        // Step held high for two edges advances two generations
        do_write(4'h5, 16'h0800);
        do_write(4'h6, 16'h0300);
        step = 1'b1;
        tick();
        read(4'h6);
        check("held_step_gen1", valo, 16'h1110);
        tick();
        step = 1'b0;
        read(4'h6);
        check("held_step_gen2_b6", valo, 16'h0300);
        check("held_step_gen2_prev", valo_prev, 16'h1110);
        read(4'h5);
        check("held_step_gen2_b5", valo, 16'h0800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
